serial_adder: RTL and testbench
===============================

SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 SHALL have parameter: WIDTH, 8, operand/result width in bits (>=2).
REQ-002 SHALL have parameter: DIGIT, 1, bits added per clock cycle; WIDTH mod DIGIT != 0 SHALL fail elaboration.
REQ-003 SHALL have port: clk  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port: rstn  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port: in_valid  input  1  operand set presented.
REQ-006 SHALL have port: in_ready  output  1  block can accept operands.
REQ-007 SHALL have port: a  input  WIDTH  operand A.
REQ-008 SHALL have port: b  input  WIDTH  operand B.
REQ-009 SHALL have port: c_in  input  1  carry-in.
REQ-010 SHALL have port: sub  input  1  subtract select (present only with SUB_MODE_EN).
REQ-011 SHALL have port: out_valid  output  1  result available.
REQ-012 SHALL have port: out_ready  input  1  consumer takes result.
REQ-013 SHALL have port: sum  output  WIDTH  result.
REQ-014 SHALL have port: c_out  output  1  carry-out of MSB.

Function
REQ-015 SHALL implement FSM states IDLE, RUN, DONE; N = WIDTH/DIGIT.
REQ-016 SHALL drive in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-017 SHALL, on rising edge with in_valid&&in_ready, capture a, b, c_in (and sub), clear digit counter, and enter RUN.
REQ-018 SHALL, in each RUN cycle, add the DIGIT LSBs of the shifted A and B with the running carry, shift the DIGIT result bits in from the MSB end of the sum register, update the carry, and increment the counter.
REQ-019 SHALL leave RUN for DONE on the edge completing digit N-1; acceptance edge E gives out_valid=1 from edge E+N (latency N cycles).
REQ-020 SHALL produce sum = (a+b+c_in) mod 2^WIDTH and c_out = bit WIDTH of a+b+c_in.
REQ-021 SHALL hold sum and c_out stable while out_valid=1 and out_ready=0 (indefinite backpressure).
REQ-022 SHALL return to IDLE on rising edge with out_valid&&out_ready; in_ready rises in the following cycle (no same-cycle accept in DONE).
REQ-023 SHALL ignore in_valid, a, b, c_in changes during RUN and DONE.
REQ-024 SHALL keep sum/c_out at the last delivered result while in IDLE.
REQ-025 SHALL handle wrap-around: all-ones + all-ones + 1 gives sum all-ones, c_out=1.

Reset
REQ-026 SHALL, on rising edge with rstn=0, enter IDLE, clear counter, sum=0, c_out=0, out_valid=0, in_ready=1 from the next cycle.
REQ-027 SHALL abort any operation in RUN or DONE on reset, discarding it; no out_valid pulse after reset release.
REQ-028 SHALL give rstn priority over every simultaneous handshake.

Configuration
REQ-029 SHALL compile subtract mode only when macro SERIAL_ADDER_SUB_MODE_EN is defined.
REQ-030 With SERIAL_ADDER_SUB_MODE_EN defined: port sub exists; sub=1 captured SHALL give sum = (a-b-c_in) mod 2^WIDTH computed as a+~b+!c_in, c_out=1 meaning no borrow; sub=0 behaves as addition.
REQ-031 Without SERIAL_ADDER_SUB_MODE_EN: port sub absent, addition only, logic identical to sub=0.

Verification
REQ-032 WIDTH=8, DIGIT=1: a=0x5A, b=0x33, c_in=1, out_ready=1 -> out_valid exactly 8 cycles after accept edge, sum=0x8E, c_out=0.
REQ-033 WIDTH=8, DIGIT=4: a=0xFF, b=0xFF, c_in=1 -> out_valid 2 cycles after accept, sum=0xFF, c_out=1.
REQ-034 Backpressure: out_ready=0 for 5 cycles after out_valid -> sum/c_out stable, in_ready=0, new in_valid ignored; out_ready=1 -> IDLE next edge.
REQ-035 Reset mid-RUN: rstn=0 at digit 3 of 8 -> next cycle out_valid=0, sum=0, c_out=0, in_ready=1; no later result.
REQ-036 SUB_MODE_EN, WIDTH=8, DIGIT=2: a=0x10, b=0x20, c_in=0, sub=1 -> sum=0xF0, c_out=0; a=0x20, b=0x10 -> sum=0x10, c_out=1.
REQ-037 Back-to-back: 16 random operand sets with in_valid held high and out_ready=1 -> every result matches reference model, one accept per N+2 cycles.

Source files
------------

// File: rtl/serial_adder.sv
// serial_adder: digit-serial adder adding DIGIT bits per clock behind valid/ready handshakes.
// Ports: clk; rstn (synchronous, active-low); in_valid/in_ready with operands a, b, c_in
// (and sub when SERIAL_ADDER_SUB_MODE_EN is defined); out_valid/out_ready with result sum, c_out.
// Optional feature: define SERIAL_ADDER_SUB_MODE_EN to add the sub port (sum = a - b - c_in,
// c_out = 1 meaning no borrow). Without it the block is an adder only.
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
`ifdef SERIAL_ADDER_SUB_MODE_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
);
  localparam int N = WIDTH / DIGIT;
  localparam int CW = N > 1 ? $clog2(N) : 1;
  if (WIDTH < 2 || DIGIT < 1 || WIDTH % DIGIT != 0) begin : g_bad_cfg
    $error("serial_adder: WIDTH must be >= 2 and a multiple of DIGIT");
  end
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, nxt;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic carry, inv, last;
  logic [CW-1:0] cnt;
  logic [DIGIT:0] d;
`ifdef SERIAL_ADDER_SUB_MODE_EN
  assign inv = sub;
`else
  assign inv = 1'b0;
`endif
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  assign last = cnt == CW'(N - 1);
  assign d = {1'b0, a_sh[DIGIT-1:0]} + {1'b0, b_sh[DIGIT-1:0]} + (DIGIT+1)'(carry);
  always_comb begin
    nxt = state == IDLE ? (in_valid ? RUN : IDLE) :
          state == RUN  ? (last ? DONE : RUN) :
                          (out_ready ? IDLE : DONE);
  end
  always_ff @(posedge clk) state <= !rstn ? IDLE : nxt;
  // Subtraction is a + ~b + !c_in, so B and the carry are conditioned once at capture
  // and the per-digit datapath stays a plain adder.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt <= '0;
      sum <= '0;
      c_out <= 1'b0;
    end else if (in_valid && in_ready) begin
      a_sh <= a;
      b_sh <= inv ? ~b : b;
      carry <= c_in ^ inv;
      cnt <= '0;
    end else if (state == RUN) begin
      a_sh <= a_sh >> DIGIT;
      b_sh <= b_sh >> DIGIT;
      carry <= d[DIGIT];
      sum <= WIDTH'({d[DIGIT-1:0], sum} >> DIGIT);
      cnt <= cnt + CW'(1);
      if (last) c_out <= d[DIGIT];
    end
  end
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: table, directed and random back-to-back checks of serial_adder.
module tb_serial_adder;
  logic clk = 0, rstn = 0, in_valid = 0, out_ready = 1, c_in = 0, sub = 0;
  logic in_valid4 = 0, out_ready4 = 1;
  logic [7:0] a = 0, b = 0;
  logic in_ready, out_valid, c_out, in_ready4, out_valid4, c_out4;
  logic [7:0] sum, sum4;
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  serial_adder #(.WIDTH(8), .DIGIT(1)) u1 (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .c_in(c_in),
`ifdef SERIAL_ADDER_SUB_MODE_EN
    .sub(sub),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .c_out(c_out));
  serial_adder #(.WIDTH(8), .DIGIT(4)) u4 (
    .clk(clk), .rstn(rstn), .in_valid(in_valid4), .in_ready(in_ready4), .a(a), .b(b), .c_in(c_in),
`ifdef SERIAL_ADDER_SUB_MODE_EN
    .sub(sub),
`endif
    .out_valid(out_valid4), .out_ready(out_ready4), .sum(sum4), .c_out(c_out4));
  typedef struct {
    logic [7:0] a, b;
    logic ci;
    logic [7:0] s;
    logic co;
  } vec_t;
  vec_t tbl[7];
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, got, exp);
    end
  endtask
  function automatic logic [8:0] model(input logic [7:0] x, input logic [7:0] y, input logic ci, input logic s);
    return s ? {1'b0, x} + {1'b0, ~y} + 9'(!ci) : {1'b0, x} + {1'b0, y} + 9'(ci);
  endfunction
  task automatic op(input logic [7:0] x, input logic [7:0] y, input logic ci, input logic s,
                    output logic [7:0] rs, output logic rc, output int lat);
    a = x; b = y; c_in = ci; sub = s; in_valid = 1;
    step;
    in_valid = 0;
    lat = 0;
    while (!out_valid && lat < 100) begin
      step;
      lat++;
    end
    rs = sum;
    rc = c_out;
  endtask
  initial begin
    logic [7:0] rs;
    logic rc, seen;
    logic [8:0] e;
    logic [8:0] q[$];
    int lat, acc, res, last_acc, cyc;
    tbl[0] = '{8'h5A, 8'h33, 1'b1, 8'h8E, 1'b0};
    tbl[1] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    tbl[2] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    tbl[3] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    tbl[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    tbl[5] = '{8'h7F, 8'h00, 1'b1, 8'h80, 1'b0};
    tbl[6] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1};
    step;
    step;
    chk("rst out_valid", out_valid, 0);
    chk("rst in_ready", in_ready, 1);
    chk("rst sum", sum, 0);
    chk("rst c_out", c_out, 0);
    rstn = 1;
    step;
    for (int i = 0; i < 7; i++) begin
      op(tbl[i].a, tbl[i].b, tbl[i].ci, 1'b0, rs, rc, lat);
      chk($sformatf("tbl%0d latency", i), lat, 8);
      chk($sformatf("tbl%0d sum", i), rs, tbl[i].s);
      chk($sformatf("tbl%0d c_out", i), rc, tbl[i].co);
      step;
    end
    out_ready = 0;
    op(8'h5A, 8'h33, 1'b1, 1'b0, rs, rc, lat);
    chk("bp latency", lat, 8);
    for (int i = 0; i < 5; i++) begin
      a = 8'($urandom); b = 8'($urandom); in_valid = 1;
      step;
      chk("bp out_valid", out_valid, 1);
      chk("bp in_ready", in_ready, 0);
      chk("bp sum", sum, 8'h8E);
      chk("bp c_out", c_out, 0);
    end
    in_valid = 0;
    out_ready = 1;
    step;
    chk("bp release out_valid", out_valid, 0);
    chk("bp release in_ready", in_ready, 1);
    step;
    chk("idle keeps sum", sum, 8'h8E);
    chk("idle keeps c_out", c_out, 0);
    a = 8'hFF; b = 8'h01; c_in = 0; in_valid = 1;
    step;
    in_valid = 0;
    step;
    step;
    step;
    rstn = 0;
    step;
    rstn = 1;
    chk("midrun rst out_valid", out_valid, 0);
    chk("midrun rst sum", sum, 0);
    chk("midrun rst c_out", c_out, 0);
    chk("midrun rst in_ready", in_ready, 1);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      step;
      seen |= out_valid;
    end
    chk("no result after reset", seen, 0);
    chk("d4 in_ready", in_ready4, 1);
    a = 8'hFF; b = 8'hFF; c_in = 1; in_valid4 = 1;
    step;
    in_valid4 = 0;
    lat = 0;
    while (!out_valid4 && lat < 20) begin
      step;
      lat++;
    end
    chk("d4 latency", lat, 2);
    chk("d4 sum", sum4, 8'hFF);
    chk("d4 c_out", c_out4, 1);
    step;
`ifdef SERIAL_ADDER_SUB_MODE_EN
    op(8'h10, 8'h20, 1'b0, 1'b1, rs, rc, lat);
    chk("sub1 sum", rs, 8'hF0);
    chk("sub1 c_out", rc, 0);
    step;
    op(8'h20, 8'h10, 1'b0, 1'b1, rs, rc, lat);
    chk("sub2 sum", rs, 8'h10);
    chk("sub2 c_out", rc, 1);
    step;
    sub = 0;
`endif
    acc = 0; res = 0; last_acc = -1; cyc = 0;
    out_ready = 1;
    in_valid = 1;
    a = 8'($urandom); b = 8'($urandom); c_in = 1'($urandom);
    while ((acc < 16 || res < 16) && cyc < 2000) begin
      if (in_valid && in_ready) begin
        q.push_back(model(a, b, c_in, sub));
        if (last_acc >= 0) chk("b2b spacing", cyc - last_acc, 10);
        last_acc = cyc;
        acc++;
      end
      if (out_valid) begin
        if (q.size() == 0) chk("b2b spurious result", 1, 0);
        else begin
          e = q.pop_front();
          chk($sformatf("b2b%0d sum", res), sum, e[7:0]);
          chk($sformatf("b2b%0d c_out", res), c_out, e[8]);
        end
        res++;
      end
      step;
      cyc++;
      if (acc == 16) in_valid = 0;
      a = 8'($urandom); b = 8'($urandom); c_in = 1'($urandom);
`ifdef SERIAL_ADDER_SUB_MODE_EN
      sub = 1'($urandom);
`endif
    end
    chk("b2b results", res, 16);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
